// File: rtl/response_system_top.sv
// response_system_top: ticket dispenser feeding five service counters (A..E) with
// fixed-length service timers and lowest-letter-first dispatch.
module response_system_top #(
   parameter int unsigned SERVICE_CYCLES = 10
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       button,
   output logic [5:0] current_number,
   output logic       counterA,
   output logic       counterB,
   output logic       counterC,
   output logic       counterD,
   output logic       counterE,
   output logic [5:0] number_service,
   output logic [3:0] counter_call,
   output logic [5:0] A_serviceNumber,
   output logic [5:0] B_serviceNumber,
   output logic [5:0] C_serviceNumber,
   output logic [5:0] D_serviceNumber,
   output logic [5:0] E_serviceNumber
);
   logic [5:0] cur_q, ns_q;
   logic [3:0] call_q;
   logic [4:0] busy_q;
   logic [5:0] sn_q [5];
   logic [7:0] tmr_q [5];
   logic [6:0] diff, wrap;
   logic [5:0] pend;
   logic [2:0] sel;
   logic       full, go;

   function automatic logic [5:0] nxt(input logic [5:0] n);
      return (n == 6'd63) ? 6'd1 : n + 6'd1;
   endfunction

   // tickets live on a 63-value ring (1..63), so 0 and 63 are the same slot
   always_comb begin
      diff = {1'b0, cur_q} - {1'b0, ns_q};
      wrap = diff + 7'd63;
      pend = diff[6] ? wrap[5:0] : (&diff[5:0] ? 6'd0 : diff[5:0]);
      full = pend == 6'd62;
      sel  = 3'd5;
      for (int i = 4; i >= 0; i--)
         if (!busy_q[i]) sel = 3'(i);
      go   = (cur_q != ns_q) && (sel != 3'd5);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cur_q  <= '0;
         ns_q   <= '0;
         call_q <= '0;
         busy_q <= '0;
         for (int i = 0; i < 5; i++) begin
            sn_q[i]  <= '0;
            tmr_q[i] <= '0;
         end
      end else begin
         if (button && !full) cur_q <= nxt(cur_q);
         if (go) begin
            ns_q   <= nxt(ns_q);
            call_q <= {1'b0, sel} + 4'd1;
         end
         for (int i = 0; i < 5; i++) begin
            if (go && sel == 3'(i)) begin
               busy_q[i] <= 1'b1;
               tmr_q[i]  <= SERVICE_CYCLES[7:0];
               sn_q[i]   <= nxt(ns_q);
            end else if (tmr_q[i] != 8'd0) begin
               tmr_q[i] <= tmr_q[i] - 8'd1;
               if (tmr_q[i] == 8'd1) busy_q[i] <= 1'b0;
            end
         end
      end
   end

   assign current_number  = cur_q;
   assign number_service  = ns_q;
   assign counter_call    = call_q;
   assign {counterE, counterD, counterC, counterB, counterA} = busy_q;
   assign A_serviceNumber = sn_q[0];
   assign B_serviceNumber = sn_q[1];
   assign C_serviceNumber = sn_q[2];
   assign D_serviceNumber = sn_q[3];
   assign E_serviceNumber = sn_q[4];
endmodule

// File: tb/tb_response_system_top.sv
// tb_response_system_top: directed checks of ticket issue, dispatch, wrap, queue-full and async reset.
module tb_response_system_top;
   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       button = 1'b0;
   logic [5:0] current_number, number_service;
   logic [3:0] counter_call;
   logic       counterA, counterB, counterC, counterD, counterE;
   logic [5:0] A_serviceNumber, B_serviceNumber, C_serviceNumber, D_serviceNumber, E_serviceNumber;
   logic [5:0] sn [5];
   logic [4:0] busy;
   int total = 0;
   int bad = 0;

   response_system_top dut (
      .clk(clk), .rst(rst), .button(button),
      .current_number(current_number),
      .counterA(counterA), .counterB(counterB), .counterC(counterC),
      .counterD(counterD), .counterE(counterE),
      .number_service(number_service), .counter_call(counter_call),
      .A_serviceNumber(A_serviceNumber), .B_serviceNumber(B_serviceNumber),
      .C_serviceNumber(C_serviceNumber), .D_serviceNumber(D_serviceNumber),
      .E_serviceNumber(E_serviceNumber)
   );

   always #5 clk = ~clk;

   assign sn   = '{A_serviceNumber, B_serviceNumber, C_serviceNumber, D_serviceNumber, E_serviceNumber};
   assign busy = {counterE, counterD, counterC, counterB, counterA};

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic chk_zero(input string tag);
      chk(tag, {current_number, number_service, counter_call, busy, sn[0], sn[1], sn[2], sn[3], sn[4]}, 64'd0);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic rst_pulse();
      rst = 1'b0;
      #2;
      rst = 1'b1;
   endtask

   function automatic int pend_of(input int c, input int n);
      int d;
      d = c - n;
      if (d < 0) d += 63;
      return d % 63;
   endfunction

   function automatic int nxt(input int n);
      return (n == 63) ? 1 : n + 1;
   endfunction

   initial begin
      int exp_cur, p, hits;
      button = 1'b1;
      repeat (3) step();
      chk_zero("rst_hold");
      rst = 1'b1;
      button = 1'b0;
      repeat (3) step();
      chk_zero("idle");

      button = 1'b1;
      step();
      button = 1'b0;
      chk("one_cur", current_number, 1);
      chk("one_ns0", number_service, 0);
      chk("one_busy0", busy, 0);
      step();
      chk("one_ns", number_service, 1);
      chk("one_busyA", busy, 5'b00001);
      chk("one_snA", sn[0], 1);
      chk("one_call", counter_call, 1);
      repeat (9) step();
      chk("one_hold", counterA, 1);
      step();
      chk("one_free", counterA, 0);

      rst_pulse();
      button = 1'b1;
      for (int j = 0; j < 6; j++) begin
         step();
         if (j == 5) button = 1'b0;
         chk("six_cur", current_number, 64'(j + 1));
         if (j >= 1) begin
            chk("six_ns", number_service, 64'(j));
            chk("six_call", counter_call, 64'(j));
            chk("six_sn", sn[j-1], 64'(j));
         end
      end
      chk("six_allbusy", busy, 5'b11111);
      repeat (5) step();
      chk("six_wait_ns", number_service, 5);
      chk("six_wait_A", counterA, 1);
      step();
      chk("six_freeA", counterA, 0);
      chk("six_freeA_ns", number_service, 5);
      step();
      chk("six_re_snA", sn[0], 6);
      chk("six_re_call", counter_call, 1);
      chk("six_re_ns", number_service, 6);
      chk("six_re_busy", busy, 5'b11101);

      #2;
      rst = 1'b0;
      #1;
      chk_zero("async_rst");
      #2;
      rst = 1'b1;
      repeat (3) step();
      chk_zero("post_rst");

      for (int t = 1; t <= 63; t++) begin
         button = 1'b1;
         step();
         button = 1'b0;
         chk("wrap_cur", current_number, 64'(t));
         step();
         step();
      end
      repeat (20) step();
      chk("wrap_ns63", number_service, 63);
      chk("wrap_busy0", busy, 0);
      button = 1'b1;
      step();
      button = 1'b0;
      chk("wrap_cur1", current_number, 1);
      step();
      chk("wrap_ns1", number_service, 1);
      chk("wrap_call", counter_call, 1);
      chk("wrap_snA", sn[0], 1);

      rst_pulse();
      exp_cur = 0;
      hits = 0;
      button = 1'b1;
      for (int c = 0; c < 300; c++) begin
         p = pend_of(exp_cur, int'(number_service));
         step();
         if (p == 62) hits++;
         else exp_cur = nxt(exp_cur);
         chk("qfull_cur", current_number, 64'(exp_cur));
      end
      button = 1'b0;
      chk("qfull_reached", 64'(hits > 0), 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/response_system_top.md
RESPONSE_SYSTEM_TOP -- requirements
Module: response_system_top

Interface
REQ-001 The block SHALL use one clock and one reset: reset is asynchronous and active-low.
REQ-002 Parameter SERVICE_CYCLES, default 10: number of clock cycles a counter stays busy per customer (legal range 2..255).
REQ-003 clk  input  1  system clock; all state changes on its rising edge.
REQ-004 rst  input  1  asynchronous active-low reset.
REQ-005 button  input  1  ticket request; sampled on each rising clk edge, no synchronizer.
REQ-006 current_number  output  6  last ticket number issued.
REQ-007 counterA..counterE  output  1 each  busy flag of service counter A..E (1 = serving).
REQ-008 number_service  output  6  last ticket number called to a counter.
REQ-009 counter_call  output  4  code of the counter last called: 0 = none, 1..5 = A..E.
REQ-010 A_serviceNumber..E_serviceNumber  output  6 each  ticket number most recently assigned to counter A..E.

Function
REQ-011 Each rising edge with button=1 SHALL count as one press; holding button high issues one ticket per cycle.
REQ-012 A press SHALL advance current_number to next(current_number), visible after that same edge.
REQ-013 next(n) SHALL be n+1 for n<63 and 1 for n=63; ticket 0 is never issued.
REQ-014 Tickets are pending when number_service != current_number; the pending count is (current_number - number_service) mod 63.
REQ-015 A press SHALL be ignored when 62 tickets are already pending (queue full); current_number is unchanged.
REQ-016 When a ticket is pending and at least one counter is free at a rising edge, the block SHALL dispatch exactly one ticket at that edge.
REQ-017 Counter selection priority SHALL be the lowest-lettered free counter: A, then B, C, D, E.
REQ-018 A dispatch SHALL perform all of the following at one edge: number_service <= next(number_service); X_serviceNumber <= that number; counterX <= 1; counter_call <= code of X; counter X timer loaded.
REQ-019 Dispatch latency SHALL be 1 cycle: a ticket issued at edge k is dispatchable at edge k+1 at the earliest.
REQ-020 A dispatch SHALL occur only for tickets already pending before the edge; a press at the same edge is only counted.
REQ-021 A press and a dispatch at the same edge SHALL both take effect.
REQ-022 counterX SHALL stay 1 for exactly SERVICE_CYCLES cycles after dispatch, then return to 0.
REQ-023 A counter that frees at edge k SHALL be eligible for dispatch at edge k+1, not at edge k.
REQ-024 X_serviceNumber SHALL hold its last value after counterX clears; counter_call SHALL hold until the next dispatch.
REQ-025 At most one dispatch per cycle; other free counters wait for later edges.

Reset
REQ-026 When rst=0, the block SHALL immediately and asynchronously clear all state regardless of clk.
REQ-027 Reset values: current_number=0, number_service=0, counterA..E=0, counter_call=0, A..E_serviceNumber=0, all timers=0.
REQ-028 Presses SHALL be ignored while rst=0.
REQ-029 Release of rst mid-operation SHALL resume from the cleared state; no pending ticket survives reset.

Verification
REQ-030 Reset: pulse rst=0, then hold idle -> all outputs 0; no dispatch occurs.
REQ-031 One press at edge k -> current_number=1 at k; at k+1 number_service=1, counterA=1, A_serviceNumber=1, counter_call=1; counterA=0 after SERVICE_CYCLES cycles.
REQ-032 Six presses on consecutive edges k..k+5 (SERVICE_CYCLES=10):
- current_number reaches 6.
- Counters A..E take tickets 1..5 at edges k+1..k+5; counter_call steps 1..5.
- Ticket 6 waits while all counters are busy.
- counterA clears at k+11.
- At k+12: A_serviceNumber=6, counter_call=1, number_service=6.
REQ-033 Wrap-around: issue tickets with dispatch keeping up until current_number=63 -> next press gives current_number=1, and that ticket is dispatched normally.
REQ-034 Queue full: keep all counters busy and press until 62 tickets are pending -> further presses leave current_number unchanged.
REQ-035 Async reset mid-service: drive rst=0 between clock edges while counters are busy -> all outputs 0 immediately, before the next edge.
